// File: rtl/tlv_pkg.sv
// Shared definitions for the TLV seed loader: frame type codes,
// error codes and FSM state encoding.
package tlv_pkg;

  localparam logic [7:0] TYPE_SEED  = 8'h01;
  localparam logic [7:0] TYPE_START = 8'h02;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_LEN     = 3'd1,
    ERR_NO_SEED = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_OVERRUN = 3'd4,
    ERR_TYPE    = 3'd5
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN    = 3'd1,
    ST_VALUE  = 3'd2,
    ST_SKIP   = 3'd3,
    ST_STREAM = 3'd4
  } state_e;

endpackage

// File: rtl/tlv_timeout_ctr.sv
// Inter-byte watchdog: counts enabled cycles since the last reload and
// flags expiry once TIMEOUT_CYCLES idle cycles have elapsed.
module tlv_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] cnt;

  // Saturating idle-cycle counter, restarted by every received byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       cnt <= '0;
    else if (reload)                cnt <= '0;
    else if (enable && cnt != LIMIT) cnt <= cnt + W'(1);
  end

  assign expire = enable && (cnt == LIMIT);

endmodule

// File: rtl/tlv_seed_loader.sv
// Parses TYPE/LEN/VALUE frames from a UART byte stream, buffers a seed
// and streams it one word per cycle when a START frame arrives.
// Handshake: rx_done is a one-cycle strobe qualifying rx_data; seed is
// qualified by seed_valid with no back-pressure (the consumer must take
// one word per cycle for SEED_WORDS consecutive cycles).
module tlv_seed_loader
  import tlv_pkg::*;
#(
  parameter int SEED_WORDS     = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [31:0] seed,
  output logic        seed_valid,
  output logic        seed_loaded,
  output logic        busy,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [2:0]  dbg_state
);

  localparam int BI = $clog2(4 * SEED_WORDS);
  localparam int WI = $clog2(SEED_WORDS);
  localparam logic [7:0]    SEED_LEN  = 8'(4 * SEED_WORDS);
  localparam logic [BI-1:0] LAST_BYTE = BI'(4 * SEED_WORDS - 1);
  localparam logic [WI-1:0] LAST_WORD = WI'(SEED_WORDS - 1);

  state_e        state, state_d;
  err_code_e     err_code_q;
  logic [7:0]    type_q;
  logic [BI-1:0] idx;
  logic [7:0]    skip_cnt;
  logic [WI-1:0] word_idx;
  logic [31:0]   buffer [SEED_WORDS];
  logic          tmo_en, expire;

  assign tmo_en     = (state == ST_LEN) || (state == ST_VALUE) || (state == ST_SKIP);
  assign seed_valid = (state == ST_STREAM);
  assign seed       = seed_valid ? buffer[word_idx] : 32'h0;
  assign busy       = (state != ST_IDLE);
  assign err_code   = err_code_q;
  assign dbg_state  = state;

  tlv_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .reload (rx_done),
    .enable (tmo_en),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_d;
  end

  // Next-state decode; a byte arriving on the expiry cycle wins over the timeout.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:
        if (rx_done && rx_data != 8'h00) state_d = ST_LEN;
      ST_LEN:
        if (rx_done) begin
          if (type_q == TYPE_SEED && rx_data == SEED_LEN)               state_d = ST_VALUE;
          else if (type_q == TYPE_START && rx_data == 8'h00 && seed_loaded) state_d = ST_STREAM;
          else if (rx_data == 8'h00)                                     state_d = ST_IDLE;
          else                                                           state_d = ST_SKIP;
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      ST_VALUE:
        if (rx_done) begin
          if (idx == LAST_BYTE) state_d = ST_IDLE;
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      ST_SKIP:
        if (rx_done) begin
          if (skip_cnt == 8'd1) state_d = ST_IDLE;
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      ST_STREAM:
        if (word_idx == LAST_WORD) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Frame bookkeeping, seed ownership and error reporting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      type_q      <= 8'h00;
      idx         <= '0;
      skip_cnt    <= 8'h00;
      word_idx    <= '0;
      seed_loaded <= 1'b0;
      err         <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE:
          if (rx_done && rx_data != 8'h00) type_q <= rx_data;
        ST_LEN:
          if (rx_done) begin
            skip_cnt <= rx_data;
            if (type_q == TYPE_SEED) begin
              if (rx_data == SEED_LEN) idx <= '0;
              else begin err <= 1'b1; err_code_q <= ERR_LEN; end
            end else if (type_q == TYPE_START) begin
              if (rx_data != 8'h00)  begin err <= 1'b1; err_code_q <= ERR_LEN; end
              else if (seed_loaded)  word_idx <= '0;
              else                   begin err <= 1'b1; err_code_q <= ERR_NO_SEED; end
            end else begin
              err <= 1'b1; err_code_q <= ERR_TYPE;
            end
          end else if (expire) begin
            err <= 1'b1; err_code_q <= ERR_TIMEOUT;
          end
        ST_VALUE:
          if (rx_done) begin
            if (idx == '0) seed_loaded <= 1'b0;
            if (idx == LAST_BYTE) begin
              seed_loaded <= 1'b1;
              err         <= 1'b0;
            end else begin
              idx <= idx + BI'(1);
            end
          end else if (expire) begin
            err <= 1'b1; err_code_q <= ERR_TIMEOUT;
            seed_loaded <= 1'b0;
          end
        ST_SKIP:
          if (rx_done) skip_cnt <= skip_cnt - 8'd1;
          else if (expire) begin err <= 1'b1; err_code_q <= ERR_TIMEOUT; end
        ST_STREAM: begin
          if (rx_done) begin err <= 1'b1; err_code_q <= ERR_OVERRUN; end
          if (word_idx == LAST_WORD) seed_loaded <= 1'b0;
          else                       word_idx <= word_idx + WI'(1);
        end
        default: ;
      endcase
    end
  end

  // Seed buffer: little-endian byte packing, deliberately not reset.
  always_ff @(posedge clk) begin
    if (state == ST_VALUE && rx_done)
      buffer[idx[BI-1:2]][{idx[1:0], 3'b000} +: 8] <= rx_data;
  end

endmodule

// File: tb/tb_tlv_seed_loader.sv
// Directed bench for tlv_seed_loader: frame parsing, streaming, error
// codes, timeout boundary and asynchronous reset.
module tb_tlv_seed_loader;
  import tlv_pkg::*;

  localparam int SEED_WORDS     = 16;
  localparam int TIMEOUT_CYCLES = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] seed;
  logic        seed_valid, seed_loaded, busy, err;
  logic [2:0]  err_code, dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  tlv_seed_loader #(.SEED_WORDS(SEED_WORDS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .seed        (seed),
    .seed_valid  (seed_valid),
    .seed_loaded (seed_loaded),
    .busy        (busy),
    .err         (err),
    .err_code    (err_code),
    .dbg_state   (dbg_state)
  );

  // Pattern 0: byte i = i; pattern 1: byte i = i ^ 0xA5.
  function automatic logic [7:0] pat_byte(int pat, int i);
    logic [7:0] b;
    b = 8'(i);
    return (pat == 0) ? b : (b ^ 8'hA5);
  endfunction

  function automatic logic [31:0] pat_word(int pat, int k);
    return {pat_byte(pat, 4*k+3), pat_byte(pat, 4*k+2), pat_byte(pat, 4*k+1), pat_byte(pat, 4*k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic load_seed(input int pat);
    send_byte(8'h01);
    send_byte(8'h40);
    for (int i = 0; i < 4*SEED_WORDS; i++) send_byte(pat_byte(pat, i));
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({seed_valid, seed, seed_loaded, busy, err, err_code} !== 38'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b seed=%h loaded=%0b busy=%0b err=%0b code=%0d expected all 0",
               seed_valid, seed, seed_loaded, busy, err, err_code);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_start_no_seed();
    int highs;
    send_byte(8'h02);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL nos_busy_len: got %0b expected 1", busy); end
    send_byte(8'h00);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      if (seed_valid === 1'b1) highs++;
      tick();
    end
    checks++;
    if (highs !== 0) begin errors++; $display("FAIL nos_no_stream: got %0d valid cycles expected 0", highs); end
    checks++;
    if ({err, err_code, busy} !== {1'b1, 3'd2, 1'b0}) begin
      errors++; $display("FAIL nos_err: got err=%0b code=%0d busy=%0b expected err=1 code=2 busy=0", err, err_code, busy);
    end
  endtask

  task automatic test_load_and_stream();
    load_seed(0);
    checks++;
    if ({seed_loaded, err, busy} !== 3'b100) begin
      errors++; $display("FAIL ld_flags: got loaded=%0b err=%0b busy=%0b expected 1 0 0", seed_loaded, err, busy);
    end
    send_byte(8'h00);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ld_zero_ignored: got busy=%0b expected 0", busy); end
    send_byte(8'h02);
    checks++;
    if ({busy, seed_valid} !== 2'b10) begin
      errors++; $display("FAIL ld_start_len: got busy=%0b valid=%0b expected 1 0", busy, seed_valid);
    end
    send_byte(8'h00);
    checks++;
    if (seed !== 32'h03020100) begin errors++; $display("FAIL ld_word0: got %h expected 03020100", seed); end
    for (int k = 0; k < SEED_WORDS; k++) begin
      checks++;
      if ({seed_valid, seed} !== {1'b1, pat_word(0, k)}) begin
        errors++; $display("FAIL ld_word%0d: got valid=%0b seed=%h expected 1 %h", k, seed_valid, seed, pat_word(0, k));
      end
      if (k == SEED_WORDS - 1) begin
        checks++;
        if (seed !== 32'h3F3E3D3C) begin errors++; $display("FAIL ld_word15: got %h expected 3f3e3d3c", seed); end
      end
      tick();
    end
    checks++;
    if ({seed_valid, seed, seed_loaded, busy} !== 35'h0) begin
      errors++; $display("FAIL ld_after: got valid=%0b seed=%h loaded=%0b busy=%0b expected 0", seed_valid, seed, seed_loaded, busy);
    end
  endtask

  task automatic test_bad_len();
    send_byte(8'h01);
    send_byte(8'h10);
    checks++;
    if ({err_code, dbg_state} !== {3'd1, ST_SKIP}) begin
      errors++; $display("FAIL bl_code: got code=%0d state=%0d expected 1 %0d", err_code, dbg_state, ST_SKIP);
    end
    for (int i = 0; i < 15; i++) send_byte(8'(i + 8'h40));
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bl_busy_15: got %0b expected 1", busy); end
    send_byte(8'h4F);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bl_idle_16: got %0b expected 0", busy); end
    send_byte(8'h02);
    send_byte(8'h00);
    checks++;
    if ({seed_valid, err_code, busy} !== {1'b0, 3'd2, 1'b0}) begin
      errors++; $display("FAIL bl_no_reuse: got valid=%0b code=%0d busy=%0b expected 0 2 0", seed_valid, err_code, busy);
    end
  endtask

  task automatic test_overrun();
    load_seed(0);
    load_seed(1);
    send_byte(8'h01); send_byte(8'h04);
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    checks++;
    if ({err_code, busy} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL ov_skip4: got code=%0d busy=%0b expected 1 0", err_code, busy);
    end
    send_byte(8'h07); send_byte(8'h02);
    checks++;
    if ({err_code, busy} !== {3'd5, 1'b1}) begin
      errors++; $display("FAIL ov_type: got code=%0d busy=%0b expected 5 1", err_code, busy);
    end
    send_byte(8'hEE); send_byte(8'hEE);
    send_byte(8'h02); send_byte(8'h01);
    checks++;
    if ({err_code, busy} !== {3'd1, 1'b1}) begin
      errors++; $display("FAIL ov_start_len: got code=%0d busy=%0b expected 1 1", err_code, busy);
    end
    send_byte(8'h33);
    send_byte(8'h07); send_byte(8'h00);
    checks++;
    if ({err_code, busy, seed_loaded} !== {3'd5, 1'b0, 1'b1}) begin
      errors++; $display("FAIL ov_type0: got code=%0d busy=%0b loaded=%0b expected 5 0 1", err_code, busy, seed_loaded);
    end
    for (int k = 0; k < SEED_WORDS; k++) exp_q.push_back(pat_word(1, k));
    send_byte(8'h02);
    send_byte(8'h00);
    for (int k = 0; k < SEED_WORDS; k++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({seed_valid, seed} !== {1'b1, e}) begin
        errors++; $display("FAIL ov_word%0d: got valid=%0b seed=%h expected 1 %h", k, seed_valid, seed, e);
      end
      if (k == 3) send_byte(8'h55);
      else        tick();
    end
    checks++;
    if ({seed_valid, err, err_code, busy, seed_loaded} !== {1'b0, 1'b1, 3'd4, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ov_after: got valid=%0b err=%0b code=%0d busy=%0b loaded=%0b expected 0 1 4 0 0",
                         seed_valid, err, err_code, busy, seed_loaded);
    end
  endtask

  task automatic test_timeout();
    load_seed(0);
    send_byte(8'h01); send_byte(8'h40);
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    checks++;
    if ({seed_loaded, busy} !== 2'b01) begin
      errors++; $display("FAIL to_partial: got loaded=%0b busy=%0b expected 0 1", seed_loaded, busy);
    end
    repeat (TIMEOUT_CYCLES - 1) tick();
    checks++;
    if (dbg_state !== ST_VALUE) begin
      errors++; $display("FAIL to_early: got state=%0d expected %0d", dbg_state, ST_VALUE);
    end
    repeat (2) tick();
    checks++;
    if ({dbg_state, err, err_code, seed_loaded} !== {ST_IDLE, 1'b1, 3'd3, 1'b0}) begin
      errors++; $display("FAIL to_expired: got state=%0d err=%0b code=%0d loaded=%0b expected 0 1 3 0",
                         dbg_state, err, err_code, seed_loaded);
    end
    send_byte(8'h02); send_byte(8'h00);
    checks++;
    if ({seed_valid, err_code} !== {1'b0, 3'd2}) begin
      errors++; $display("FAIL to_start: got valid=%0b code=%0d expected 0 2", seed_valid, err_code);
    end
  endtask

  task automatic test_reset_mid_stream();
    int highs;
    load_seed(0);
    send_byte(8'h02); send_byte(8'h00);
    repeat (5) tick();
    checks++;
    if ({seed_valid, seed} !== {1'b1, pat_word(0, 5)}) begin
      errors++; $display("FAIL rs_word5: got valid=%0b seed=%h expected 1 %h", seed_valid, seed, pat_word(0, 5));
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({seed_valid, seed, seed_loaded, busy, err, err_code} !== 38'h0) begin
      errors++; $display("FAIL rs_async: got valid=%0b seed=%h loaded=%0b busy=%0b err=%0b code=%0d expected all 0",
                         seed_valid, seed, seed_loaded, busy, err, err_code);
    end
    tick(); tick();
    rst = 1'b1;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      if (seed_valid === 1'b1) highs++;
      tick();
    end
    checks++;
    if (highs !== 0) begin errors++; $display("FAIL rs_no_resume: got %0d valid cycles expected 0", highs); end
    send_byte(8'h02); send_byte(8'h00);
    checks++;
    if ({seed_valid, err_code} !== {1'b0, 3'd2}) begin
      errors++; $display("FAIL rs_start: got valid=%0b code=%0d expected 0 2", seed_valid, err_code);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start_no_seed();
    test_load_and_stream();
    test_bad_len();
    test_overrun();
    test_timeout();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
